// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 constants and PRGA state encoding
package arc4_pkg;

  localparam int S_SIZE = 256;
  localparam int IDX_W = $clog2(S_SIZE);
  localparam logic [7:0] LEN_IDX = 8'd0;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_LEN_RD = 4'd1;
  localparam state_t ST_LEN_WR = 4'd2;
  localparam state_t ST_SI_RD  = 4'd3;
  localparam state_t ST_SJ_RD  = 4'd4;
  localparam state_t ST_SWAP_I = 4'd5;
  localparam state_t ST_SWAP_J = 4'd6;
  localparam state_t ST_K_RD   = 4'd7;
  localparam state_t ST_PT_WR  = 4'd8;
  localparam state_t ST_DONE   = 4'd9;

endpackage

// File: rtl/prga_stream.sv
// rtl/prga_stream.sv - ARC4 keystream generator decrypting ct[] into pt[] on the fly
module prga_stream
  import arc4_pkg::*;
#(
  parameter int DROP    = 0,
  parameter int RD_LAT  = 1,
  parameter int MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       done,
  input  logic       abort,
  output logic       len_err,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  localparam logic [9:0] DROP_N    = 10'(DROP);
  localparam logic [7:0] MAX_L     = 8'(MAX_LEN);
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_t           state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic [7:0]       k_q, k_d, si_q, si_d, sj_q, sj_d, len_q, len_d;
  logic [9:0]       drop_q, drop_d;
  logic             len_err_q, len_err_d;
  logic             rd_last, in_drop, last_drop;
  logic [7:0]       j_sum;

  assign rd_last   = (wait_q == LAST_WAIT);
  assign in_drop   = (drop_q != DROP_N);
  assign last_drop = ((drop_q + 10'd1) == DROP_N);
  // si arrives on the first SJ_RD cycle; later wait cycles use the latched copy
  assign j_sum     = j_q + ((wait_q == 2'd0) ? s_rddata : si_q);
  assign rdy       = (state_q == ST_IDLE);
  assign len_err   = len_err_q;

  always_comb begin
    state_d   = state_q;
    wait_d    = 2'd0;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    len_d     = len_q;
    drop_d    = drop_q;
    len_err_d = len_err_q;
    done      = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = 8'd0;
          drop_d  = 10'd0;
          state_d = ST_LEN_RD;
        end
      end
      ST_LEN_RD: begin
        ct_addr = LEN_IDX;
        wait_d  = rd_last ? 2'd0 : wait_q + 2'd1;
        if (rd_last) state_d = ST_LEN_WR;
      end
      ST_LEN_WR: begin
        len_d   = ct_rddata;
        pt_addr = LEN_IDX;
        pt_wren = 1'b1;
        if (ct_rddata > MAX_L) begin
          len_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          len_err_d = 1'b0;
          pt_wrdata = ct_rddata;
          state_d   = (ct_rddata == 8'd0 && DROP_N == 10'd0) ? ST_DONE : ST_SI_RD;
        end
      end
      ST_SI_RD: begin
        s_addr = i_q + 8'd1;
        wait_d = rd_last ? 2'd0 : wait_q + 2'd1;
        if (rd_last) begin
          i_d     = i_q + 8'd1;
          state_d = ST_SJ_RD;
        end
      end
      ST_SJ_RD: begin
        s_addr = j_sum;
        wait_d = rd_last ? 2'd0 : wait_q + 2'd1;
        if (wait_q == 2'd0) si_d = s_rddata;
        if (rd_last) begin
          j_d     = j_sum;
          state_d = ST_SWAP_I;
        end
      end
      ST_SWAP_I: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = ST_SWAP_J;
      end
      ST_SWAP_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        if (in_drop) begin
          drop_d  = drop_q + 10'd1;
          state_d = (last_drop && len_q == 8'd0) ? ST_DONE : ST_SI_RD;
        end else begin
          state_d = ST_K_RD;
        end
      end
      ST_K_RD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q + 8'd1;
        wait_d  = rd_last ? 2'd0 : wait_q + 2'd1;
        if (rd_last) state_d = ST_PT_WR;
      end
      ST_PT_WR: begin
        pt_addr   = k_q + 8'd1;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        k_d       = k_q + 8'd1;
        state_d   = ((k_q + 8'd1) == len_q) ? ST_DONE : ST_SI_RD;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      wait_d    = 2'd0;
      len_err_d = len_err_q;
      done      = 1'b0;
      s_wren    = 1'b0;
      pt_wren   = 1'b0;
    end
    // a reset cycle must never leak a write into S or PT
    if (!rst_n) begin
      done    = 1'b0;
      s_wren  = 1'b0;
      pt_wren = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= 2'd0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= 8'd0;
      si_q      <= 8'd0;
      sj_q      <= 8'd0;
      len_q     <= 8'd0;
      drop_q    <= 10'd0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      len_q     <= len_d;
      drop_q    <= drop_d;
      len_err_q <= len_err_d;
    end
  end

endmodule

// File: tb/tb_prga_stream.sv
// tb/tb_prga_stream.sv - self-checking bench for prga_stream with three parameter sets
module tb_prga_stream;

  localparam int P_DROP [3] = '{0, 1, 0};
  localparam int P_LAT  [3] = '{1, 1, 3};
  localparam int P_MAX  [3] = '{255, 16, 255};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en [3], abort [3], load [3];
  logic       rdy [3], done [3], len_err [3], s_wren [3], pt_wren [3];
  logic [7:0] s_addr [3], s_rddata [3], s_wrdata [3];
  logic [7:0] ct_addr [3], ct_rddata [3], pt_addr [3], pt_wrdata [3];

  logic [7:0] s_mem [3][256], ct_mem [3][256], pt_mem [3][256];
  logic [7:0] s_pipe [3][3], ct_pipe [3][3];
  logic [7:0] s_stage [256], ct_stage [256];

  logic [7:0] exp_pt [256], exp_s [256];
  int         exp_len, exp_n, exp_swr, last_n;
  logic       exp_err;
  int         n_cmp, n_fail;

  prga_stream #(.DROP(0), .RD_LAT(1), .MAX_LEN(255)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .done(done[0]), .abort(abort[0]),
    .len_err(len_err[0]), .s_addr(s_addr[0]), .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]),
    .s_wren(s_wren[0]), .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]), .pt_addr(pt_addr[0]),
    .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]));

  prga_stream #(.DROP(1), .RD_LAT(1), .MAX_LEN(16)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .done(done[1]), .abort(abort[1]),
    .len_err(len_err[1]), .s_addr(s_addr[1]), .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]),
    .s_wren(s_wren[1]), .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]), .pt_addr(pt_addr[1]),
    .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]));

  prga_stream #(.DROP(0), .RD_LAT(3), .MAX_LEN(255)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .done(done[2]), .abort(abort[2]),
    .len_err(len_err[2]), .s_addr(s_addr[2]), .s_rddata(s_rddata[2]), .s_wrdata(s_wrdata[2]),
    .s_wren(s_wren[2]), .ct_addr(ct_addr[2]), .ct_rddata(ct_rddata[2]), .pt_addr(pt_addr[2]),
    .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]));

  // synchronous memories: data appears P_LAT cycles after the address is presented
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (load[g]) begin
        for (int x = 0; x < 256; x++) begin
          s_mem[g][x]  <= s_stage[x];
          ct_mem[g][x] <= ct_stage[x];
          pt_mem[g][x] <= 8'hEE;
        end
      end else begin
        if (s_wren[g] === 1'b1) s_mem[g][s_addr[g]] <= s_wrdata[g];
        if (pt_wren[g] === 1'b1) pt_mem[g][pt_addr[g]] <= pt_wrdata[g];
      end
      s_pipe[g][0]  <= s_mem[g][s_addr[g]];
      s_pipe[g][1]  <= s_pipe[g][0];
      s_pipe[g][2]  <= s_pipe[g][1];
      ct_pipe[g][0] <= ct_mem[g][ct_addr[g]];
      ct_pipe[g][1] <= ct_pipe[g][0];
      ct_pipe[g][2] <= ct_pipe[g][1];
    end
  end

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      s_rddata[g]  = s_pipe[g][P_LAT[g] - 1];
      ct_rddata[g] = ct_pipe[g][P_LAT[g] - 1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stage_identity();
    for (int x = 0; x < 256; x++) s_stage[x] = 8'(x);
  endtask

  task automatic stage_random_perm();
    logic [7:0] t;
    int r;
    stage_identity();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_stage[x]; s_stage[x] = s_stage[r]; s_stage[r] = t;
    end
  endtask

  task automatic stage_random_ct(input int len);
    for (int x = 0; x < 256; x++) ct_stage[x] = 8'($urandom);
    ct_stage[0] = 8'(len);
  endtask

  // plain RC4 PRGA over a copy of the staged S, plus the closed-form cycle count
  task automatic model(input int g);
    logic [7:0] s [256];
    logic [7:0] i, j, t, kx;
    int len, drop, lat;
    drop = P_DROP[g];
    lat  = P_LAT[g];
    for (int x = 0; x < 256; x++) s[x] = s_stage[x];
    len = int'(ct_stage[0]);
    if (len > P_MAX[g]) begin
      exp_err = 1'b1; exp_pt[0] = 8'd0; exp_len = 0; exp_swr = 0;
      exp_n = (1 + lat) + 1;
    end else begin
      exp_err = 1'b0; exp_pt[0] = 8'(len); exp_len = len;
      i = 8'd0; j = 8'd0;
      for (int b = 0; b < drop + len; b++) begin
        i = i + 8'd1;
        j = j + s[i];
        t = s[i]; s[i] = s[j]; s[j] = t;
        kx = s[i] + s[j];
        if (b >= drop) exp_pt[b - drop + 1] = s[kx] ^ ct_stage[b - drop + 1];
      end
      exp_swr = 2 * (drop + len);
      exp_n = (1 + lat) + drop * (2 + 2 * lat) + len * (3 + 3 * lat) + 1;
    end
    for (int x = 0; x < 256; x++) exp_s[x] = s[x];
  endtask

  task automatic do_load(input int g);
    @(negedge clk); load[g] = 1'b1;
    @(negedge clk); load[g] = 1'b0;
  endtask

  task automatic run_case(input int g, input string tag);
    int n, swr, mism;
    do_load(g);
    model(g);
    check({tag, " rdy_before"}, 32'(rdy[g]), 32'd1);
    en[g] = 1'b1;
    @(negedge clk); en[g] = 1'b0;
    n = 1; swr = 0;
    while (done[g] !== 1'b1 && n < 5000) begin
      if (s_wren[g] === 1'b1) swr++;
      @(negedge clk); n++;
    end
    last_n = n;
    check({tag, " latency"}, 32'(n), 32'(exp_n));
    check({tag, " rdy_in_done"}, 32'(rdy[g]), 32'd0);
    check({tag, " len_err"}, 32'(len_err[g]), 32'(exp_err));
    check({tag, " s_writes"}, 32'(swr), 32'(exp_swr));
    for (int x = 0; x <= exp_len; x++)
      check($sformatf("%s pt[%0d]", tag, x), 32'(pt_mem[g][x]), 32'(exp_pt[x]));
    if (exp_len < 255)
      check({tag, " pt_past_end"}, 32'(pt_mem[g][exp_len + 1]), 32'hEE);
    mism = 0;
    for (int x = 0; x < 256; x++) if (s_mem[g][x] !== exp_s[x]) mism++;
    check({tag, " s_final_mismatches"}, 32'(mism), 32'd0);
    @(negedge clk);
    check({tag, " rdy_after"}, 32'(rdy[g]), 32'd1);
    check({tag, " done_after"}, 32'(done[g]), 32'd0);
  endtask

  task automatic start_and_wait(input int g, input int cyc);
    int n;
    en[g] = 1'b1;
    @(negedge clk); en[g] = 1'b0;
    n = 1;
    while (n < cyc) begin @(negedge clk); n++; end
  endtask

  initial begin
    int dc, mism;
    logic prev_err;
    n_cmp = 0; n_fail = 0;
    for (int g = 0; g < 3; g++) begin en[g] = 1'b0; abort[g] = 1'b0; load[g] = 1'b0; end
    stage_identity();
    stage_random_ct(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset rdy", 32'(rdy[0]), 32'd1);
    check("reset done", 32'(done[0]), 32'd0);
    check("reset len_err", 32'(len_err[1]), 32'd0);
    check("reset wren", {30'd0, s_wren[0], pt_wren[0]}, 32'd0);
    check("reset addr_data", {s_addr[0], s_wrdata[0], ct_addr[0], pt_addr[0]}, 32'd0);
    check("reset pt_wrdata", 32'(pt_wrdata[0]), 32'd0);

    stage_identity();
    for (int x = 0; x < 256; x++) ct_stage[x] = 8'd0;
    ct_stage[0] = 8'd3;
    run_case(0, "id_drop0");
    check("id_drop0 const_latency", 32'(last_n), 32'd21);
    check("id_drop0 const_pt", {8'd0, pt_mem[0][1], pt_mem[0][2], pt_mem[0][3]}, 32'h0002_0507);

    run_case(1, "id_drop1");
    check("id_drop1 const_latency", 32'(last_n), 32'd25);
    check("id_drop1 const_pt", {8'd0, pt_mem[1][1], pt_mem[1][2], pt_mem[1][3]}, 32'h0005_070D);

    ct_stage[0] = 8'd2; ct_stage[1] = 8'hFF; ct_stage[2] = 8'hFF;
    run_case(2, "id_lat3");
    check("id_lat3 const_pt", {16'd0, pt_mem[2][1], pt_mem[2][2]}, 32'h0000_FDFA);

    ct_stage[0] = 8'd0;
    run_case(0, "len0");
    check("len0 const_latency", 32'(last_n), 32'd3);
    run_case(1, "len0_drop1");

    stage_random_perm(); stage_random_ct(17);
    run_case(1, "len17_err");
    stage_random_perm(); stage_random_ct(16);
    run_case(1, "len16_max");
    stage_random_perm(); stage_random_ct(255);
    run_case(0, "len255");

    for (int r = 0; r < 4; r++) begin
      stage_random_perm(); stage_random_ct($urandom_range(40, 1));
      run_case(0, $sformatf("rnd0_%0d", r));
      stage_random_perm(); stage_random_ct($urandom_range(16, 1));
      run_case(1, $sformatf("rnd1_%0d", r));
      stage_random_perm(); stage_random_ct($urandom_range(30, 1));
      run_case(2, $sformatf("rnd2_%0d", r));
    end

    prev_err = len_err[0];
    stage_random_perm(); stage_random_ct(5);
    do_load(0);
    start_and_wait(0, 5);
    abort[0] = 1'b1;
    #1;
    check("abort wren", {30'd0, s_wren[0], pt_wren[0]}, 32'd0);
    check("abort done", 32'(done[0]), 32'd0);
    @(negedge clk); abort[0] = 1'b0;
    check("abort rdy_next", 32'(rdy[0]), 32'd1);
    dc = 0;
    repeat (10) begin if (done[0] === 1'b1) dc++; @(negedge clk); end
    check("abort no_done", 32'(dc), 32'd0);
    check("abort len_err_kept", 32'(len_err[0]), 32'(prev_err));
    stage_random_perm(); stage_random_ct($urandom_range(20, 1));
    run_case(0, "after_abort");

    stage_random_perm(); stage_random_ct(17);
    run_case(1, "pre_reset_err");
    stage_random_perm(); stage_random_ct(6);
    do_load(0);
    start_and_wait(0, 5);
    rst_n = 1'b0;
    #1;
    check("rst s_wren_in_swap", 32'(s_wren[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    check("rst rdy_next", 32'(rdy[0]), 32'd1);
    check("rst s_wren_next", 32'(s_wren[0]), 32'd0);
    check("rst done_next", 32'(done[0]), 32'd0);
    check("rst len_err_cleared", 32'(len_err[1]), 32'd0);
    mism = 0;
    for (int x = 0; x < 256; x++) if (s_mem[0][x] !== s_stage[x]) mism++;
    check("rst s_untouched", 32'(mism), 32'd0);
    stage_random_perm(); stage_random_ct($urandom_range(20, 1));
    run_case(0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
